// File: rtl/rf_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port register file.
// Writes complete in the grant cycle; reads return a registered one-cycle response.
module rf_arbiter #(
    parameter int addr_width = 3,
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [addr_width-1:0] req0_addr,
    input  logic [data_width-1:0] req0_wdata,
    output logic                  req0_ready,

    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [addr_width-1:0] req1_addr,
    input  logic [data_width-1:0] req1_wdata,
    output logic                  req1_ready,

    output logic                  rsp0_valid,
    output logic [data_width-1:0] rsp0_data,
    output logic                  rsp1_valid,
    output logic [data_width-1:0] rsp1_data,

    output logic                  rf_w_en,
    output logic [addr_width-1:0] rf_w_addr,
    output logic [data_width-1:0] rf_w_data,
    output logic [addr_width-1:0] rf_r_addr,
    input  logic [data_width-1:0] rf_r_data,

    output logic [15:0]           conflict_cnt
);

    logic                  r_ptr;
    logic [addr_width-1:0] r_raddr;
    logic                  r_rsp0_valid;
    logic [data_width-1:0] r_rsp0_data;
    logic                  r_rsp1_valid;
    logic [data_width-1:0] r_rsp1_data;
    logic [15:0]           r_conflict_cnt;

    logic                  w_both;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_rd0;
    logic                  w_rd1;
    logic [addr_width-1:0] w_gnt_addr;

    // A lone requester always wins; under contention the pointer decides.
    assign w_both = req0_valid & req1_valid;
    assign w_gnt0 = ~reset & req0_valid & (~req1_valid | ~r_ptr);
    assign w_gnt1 = ~reset & req1_valid & (~req0_valid |  r_ptr);

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    assign w_rd0      = w_gnt0 & ~req0_we;
    assign w_rd1      = w_gnt1 & ~req1_we;
    assign w_gnt_addr = w_gnt1 ? req1_addr : req0_addr;

    assign rf_w_en   = (w_gnt0 & req0_we) | (w_gnt1 & req1_we);
    assign rf_w_addr = w_gnt_addr;
    assign rf_w_data = w_gnt1 ? req1_wdata : req0_wdata;

    // Outputs are masked by reset so a response captured just before reset never shows.
    assign rf_r_addr    = reset ? '0 : ((w_rd0 | w_rd1) ? w_gnt_addr : r_raddr);
    assign rsp0_valid   = r_rsp0_valid & ~reset;
    assign rsp1_valid   = r_rsp1_valid & ~reset;
    assign rsp0_data    = reset ? '0 : r_rsp0_data;
    assign rsp1_data    = reset ? '0 : r_rsp1_data;
    assign conflict_cnt = reset ? '0 : r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (w_gnt0) begin
            r_ptr <= 1'b1;
        end else if (w_gnt1) begin
            r_ptr <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_raddr <= '0;
        end else if (w_rd0 | w_rd1) begin
            r_raddr <= w_gnt_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp0_valid <= 1'b0;
            r_rsp0_data  <= '0;
        end else begin
            r_rsp0_valid <= w_rd0;
            if (w_rd0) begin
                r_rsp0_data <= rf_r_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp1_valid <= 1'b0;
            r_rsp1_data  <= '0;
        end else begin
            r_rsp1_valid <= w_rd1;
            if (w_rd1) begin
                r_rsp1_data <= rf_r_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflict_cnt <= '0;
        end else if (w_both && (r_conflict_cnt != 16'hFFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_rf_arbiter.sv
// Directed vector bench for rf_arbiter with a behavioural register file attached.
module tb_rf_arbiter;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int NV = 25;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_we, req0_ready;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_we, req1_ready;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic          rf_w_en;
    logic [AW-1:0] rf_w_addr, rf_r_addr;
    logic [DW-1:0] rf_w_data, rf_r_data;
    logic [15:0]   conflict_cnt;

    rf_arbiter #(.addr_width(AW), .data_width(DW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
        .rf_r_addr(rf_r_addr), .rf_r_data(rf_r_data),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [2**AW];
    initial for (int k = 0; k < 2**AW; k++) mem[k] = '0;
    always @(posedge clk) if (rf_w_en) mem[rf_w_addr] <= rf_w_data;
    assign rf_r_data = mem[rf_r_addr];

    typedef struct {
        logic          rst;
        logic          v0, we0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1, we1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          e_rdy0, e_rdy1, e_wen;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd;
        logic [AW-1:0] e_ra;
        logic          e_r0v;
        logic [DW-1:0] e_r0d;
        logic          e_r1v;
        logic [DW-1:0] e_r1d;
        logic [15:0]   e_cnt;
    } vec_t;

    vec_t tv [NV];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input int rst, v0, we0, a0, d0, v1, we1, a1, d1,
                                input int rdy0, rdy1, wen, wa, wd, ra,
                                input int r0v, r0d, r1v, r1d, cnt);
        vec_t t;
        t.rst = 1'(rst); t.v0 = 1'(v0); t.we0 = 1'(we0); t.a0 = AW'(a0); t.d0 = DW'(d0);
        t.v1 = 1'(v1); t.we1 = 1'(we1); t.a1 = AW'(a1); t.d1 = DW'(d1);
        t.e_rdy0 = 1'(rdy0); t.e_rdy1 = 1'(rdy1); t.e_wen = 1'(wen);
        t.e_wa = AW'(wa); t.e_wd = DW'(wd); t.e_ra = AW'(ra);
        t.e_r0v = 1'(r0v); t.e_r0d = DW'(r0d); t.e_r1v = 1'(r1v); t.e_r1d = DW'(r1d);
        t.e_cnt = 16'(cnt);
        return t;
    endfunction

    task automatic drive(input vec_t t);
        reset = t.rst;
        req0_valid = t.v0; req0_we = t.we0; req0_addr = t.a0; req0_wdata = t.d0;
        req1_valid = t.v1; req1_we = t.we1; req1_addr = t.a1; req1_wdata = t.d1;
    endtask

    task automatic check(input string name, input vec_t t);
        logic [63:0] got, exp;
        got = {req0_ready, req1_ready, rf_w_en,
               rf_w_en ? rf_w_addr : AW'(0), rf_w_en ? rf_w_data : DW'(0), rf_r_addr,
               rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, conflict_cnt};
        exp = {t.e_rdy0, t.e_rdy1, t.e_wen,
               t.e_wen ? t.e_wa : AW'(0), t.e_wen ? t.e_wd : DW'(0), t.e_ra,
               t.e_r0v, t.e_r0d, t.e_r1v, t.e_r1d, t.e_cnt};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got rdy=%b%b wen=%b wa=%0h wd=%h ra=%0h r0=%b/%h r1=%b/%h cnt=%h, want rdy=%b%b wen=%b wa=%0h wd=%h ra=%0h r0=%b/%h r1=%b/%h cnt=%h",
                     name, req0_ready, req1_ready, rf_w_en, rf_w_addr, rf_w_data, rf_r_addr,
                     rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, conflict_cnt,
                     t.e_rdy0, t.e_rdy1, t.e_wen, t.e_wa, t.e_wd, t.e_ra,
                     t.e_r0v, t.e_r0d, t.e_r1v, t.e_r1d, t.e_cnt);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, got, exp);
        end
    endtask

    initial begin
        //             rst v0 we a0 d0    v1 we a1 d1    | r0 r1 wen wa wd    ra r0v r0d  r1v r1d  cnt
        tv[0]  = mk(1, 0,0,0,0,        0,0,0,0,        0,0,0,0,0,       0, 0,0,     0,0,     0);
        tv[1]  = mk(1, 1,1,3,'h55,     1,0,2,0,        0,0,0,0,0,       0, 0,0,     0,0,     0);
        tv[2]  = mk(0, 1,1,3,'hA5,     0,0,0,0,        1,0,1,3,'hA5,    0, 0,0,     0,0,     0);
        tv[3]  = mk(0, 0,0,0,0,        1,0,3,0,        0,1,0,0,0,       3, 0,0,     0,0,     0);
        tv[4]  = mk(0, 0,0,0,0,        0,0,0,0,        0,0,0,0,0,       3, 0,0,     1,'hA5,  0);
        tv[5]  = mk(0, 1,1,1,'h11,     1,1,2,'h22,     1,0,1,1,'h11,    3, 0,0,     0,'hA5,  0);
        tv[6]  = mk(0, 1,1,1,'h11,     1,1,2,'h22,     0,1,1,2,'h22,    3, 0,0,     0,'hA5,  1);
        tv[7]  = mk(0, 1,0,1,0,        1,0,2,0,        1,0,0,0,0,       1, 0,0,     0,'hA5,  2);
        tv[8]  = mk(0, 1,0,1,0,        1,0,2,0,        0,1,0,0,0,       2, 1,'h11,  0,'hA5,  3);
        tv[9]  = mk(0, 1,0,1,0,        1,0,2,0,        1,0,0,0,0,       1, 0,'h11,  1,'h22,  4);
        tv[10] = mk(0, 1,0,1,0,        1,0,2,0,        0,1,0,0,0,       2, 1,'h11,  0,'h22,  5);
        tv[11] = mk(0, 0,0,0,0,        0,0,0,0,        0,0,0,0,0,       2, 0,'h11,  1,'h22,  6);
        tv[12] = mk(0, 0,0,0,0,        1,1,4,'h44,     0,1,1,4,'h44,    2, 0,'h11,  0,'h22,  6);
        tv[13] = mk(0, 0,0,0,0,        1,1,6,'h66,     0,1,1,6,'h66,    2, 0,'h11,  0,'h22,  6);
        tv[14] = mk(0, 0,0,0,0,        1,0,4,0,        0,1,0,0,0,       4, 0,'h11,  0,'h22,  6);
        tv[15] = mk(0, 1,0,6,0,        1,0,4,0,        1,0,0,0,0,       6, 0,'h11,  1,'h44,  6);
        tv[16] = mk(0, 0,0,0,0,        1,0,4,0,        0,1,0,0,0,       4, 1,'h66,  0,'h44,  7);
        tv[17] = mk(0, 1,1,5,'hC3,     1,0,5,0,        1,0,1,5,'hC3,    4, 0,'h66,  1,'h44,  7);
        tv[18] = mk(0, 0,0,0,0,        1,0,5,0,        0,1,0,0,0,       5, 0,'h66,  0,'h44,  8);
        tv[19] = mk(0, 0,0,0,0,        0,0,0,0,        0,0,0,0,0,       5, 0,'h66,  1,'hC3,  8);
        tv[20] = mk(0, 1,0,1,0,        0,0,0,0,        1,0,0,0,0,       1, 0,'h66,  0,'hC3,  8);
        tv[21] = mk(1, 0,0,0,0,        0,0,0,0,        0,0,0,0,0,       0, 0,0,     0,0,     0);
        tv[22] = mk(0, 0,0,0,0,        0,0,0,0,        0,0,0,0,0,       0, 0,0,     0,0,     0);
        tv[23] = mk(0, 1,0,3,0,        1,0,2,0,        1,0,0,0,0,       3, 0,0,     0,0,     0);
        tv[24] = mk(0, 0,0,0,0,        0,0,0,0,        0,0,0,0,0,       3, 1,'hA5,  0,0,     1);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            drive(tv[i]);
            #1;
            check($sformatf("vec%0d", i), tv[i]);
        end

        // Sustained contention: strict alternation, then counter saturation without wrap.
        @(posedge clk); #1;
        drive(mk(1, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0));
        @(posedge clk); #1;
        drive(mk(0, 1,0,1,0, 1,0,2,0, 0,0,0,0,0,0, 0,0,0,0,0));
        for (int k = 0; k < 65540; k++) begin
            #1;
            if (k < 8) begin
                check_val($sformatf("alt_rdy%0d", k), {30'd0, req0_ready, req1_ready},
                          (k % 2 == 0) ? 32'd2 : 32'd1);
            end
            if (k == 65534) check_val("cnt_fffe", {16'd0, conflict_cnt}, 32'hFFFE);
            if (k == 65535) check_val("cnt_ffff", {16'd0, conflict_cnt}, 32'hFFFF);
            if (k == 65539) check_val("cnt_nowrap", {16'd0, conflict_cnt}, 32'hFFFF);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rf_arbiter.md
RF_ARBITER -- requirements
Module: rf_arbiter

Interface
REQ-001 The block SHALL have parameter addr_width, default 3, meaning the register-file address width.
REQ-002 The block SHALL have parameter data_width, default 8, meaning the register-file data width.
REQ-003 The block SHALL have one clock and one reset; the reset SHALL be synchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, the synchronous active-high reset.
REQ-006 The block SHALL have port req0_valid, input, 1 bit, meaning requester 0 presents an access.
REQ-007 The block SHALL have port req0_we, input, 1 bit, meaning 1 = write and 0 = read.
REQ-008 The block SHALL have port req0_addr, input, addr_width bits, the access address.
REQ-009 The block SHALL have port req0_wdata, input, data_width bits, the write data.
REQ-010 The block SHALL have port req0_ready, output, 1 bit, meaning requester 0 is granted this cycle.
REQ-011 The block SHALL have ports req1_valid, req1_we, req1_addr, req1_wdata and req1_ready, identical to REQ-006 to REQ-010, for requester 1.
REQ-012 The block SHALL have port rsp0_valid, output, 1 bit, a one-cycle read-response strobe for requester 0.
REQ-013 The block SHALL have port rsp0_data, output, data_width bits, the read data for requester 0.
REQ-014 The block SHALL have ports rsp1_valid and rsp1_data, identical to REQ-012 and REQ-013, for requester 1.
REQ-015 The block SHALL have port rf_w_en, output, 1 bit, the register-file write enable.
REQ-016 The block SHALL have port rf_w_addr, output, addr_width bits, the register-file write address.
REQ-017 The block SHALL have port rf_w_data, output, data_width bits, the register-file write data.
REQ-018 The block SHALL have port rf_r_addr, output, addr_width bits, the register-file read address.
REQ-019 The block SHALL have port rf_r_data, input, data_width bits, the combinational register-file read data.
REQ-020 The block SHALL have port conflict_cnt, output, 16 bits, a saturating count of contention cycles.

Function
REQ-021 The block SHALL grant at most one requester per cycle; an access is accepted when reqN_valid and reqN_ready are both 1.
REQ-022 reqN_ready SHALL be combinational from the valids and the priority pointer; it SHALL be 0 when reqN_valid is 0.
REQ-023 With only one valid requester, that requester SHALL be granted regardless of the pointer.
REQ-024 With both requesters valid, the requester selected by the 1-bit priority pointer SHALL be granted.
REQ-025 After any accept by requester i, the pointer SHALL move to the other requester at the next edge; with no accept, the pointer SHALL hold.
REQ-026 A granted write SHALL drive rf_w_en=1, rf_w_addr=addr and rf_w_data=wdata in the grant cycle; the data SHALL be visible to reads from the next cycle.
REQ-027 rf_w_en SHALL be 0 in every cycle without a granted write.
REQ-028 rf_r_addr SHALL equal the granted address during a granted read, and SHALL otherwise hold its last value.
REQ-029 A read accepted at cycle t SHALL cause rspN_data to register rf_r_data at the t edge.
REQ-030 rspN_valid SHALL be 1 for exactly cycle t+1 following a read accepted at cycle t.
REQ-031 rspN_data SHALL hold its value until the next read response to requester N; back-to-back reads SHALL give consecutive 1-cycle strobes.
REQ-032 Writes SHALL produce no response.
REQ-033 conflict_cnt SHALL increment in each cycle in which both valids are 1, and SHALL saturate at 0xFFFF.
REQ-034 A requester holding valid SHALL be granted within 2 cycles, so no starvation occurs.

Reset
REQ-035 While reset=1: pointer=0 (requester 0 favoured), rsp0_valid=rsp1_valid=0, rsp0_data=rsp1_data=0, conflict_cnt=0, rf_r_addr=0.
REQ-036 While reset=1, both readys and rf_w_en SHALL be 0.
REQ-037 A read accepted in the cycle before reset asserts SHALL produce no response strobe; its response SHALL be discarded.

Verification
REQ-038 Scenario: reset, then req0 writes 0xA5 to address 3 -> rf_w_en=1, rf_w_addr=3 in the same cycle; req1 read of address 3 next cycle -> rsp1_valid=1, rsp1_data=0xA5 one cycle later.
REQ-039 Scenario: both requesters hold reads for 4 cycles -> grants alternate 0,1,0,1, each rsp strobes once per grant, conflict_cnt=4.
REQ-040 Scenario: req1 alone, valid for 3 cycles -> req1_ready=1 in all 3 cycles; req0 then joins -> req0 is granted first (pointer points to 0).
REQ-041 Scenario: req0 write to address 5 and req1 read of address 5 in the same cycle, pointer=0 -> write granted; read granted next cycle and returns the new data.
REQ-042 Scenario: read accepted, then reset asserted next cycle -> rsp valid stays 0 and rsp data reads 0.
REQ-043 Scenario: force 65,540 contention cycles -> conflict_cnt=0xFFFF with no wrap.
